// File: rtl/alu_sub_seq.sv
// Multi-cycle two's-complement subtractor: d = a - b - b_in, SLICE bits per clock, registered N/Z/C/O flags.
// Optional saturation on signed overflow when ALU_SUB_SAT_EN is defined; the default build wraps.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one slice of a + ~b + carry per cycle
// DONE  | out_valid high, result and flags held until out_ready
module alu_sub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             sig_N,
  output logic             sig_Z,
  output logic             sig_C,
  output logic             sig_O
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE:0]   w_slice;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;

  assign w_last = (r_state == S_RUN) && (r_cnt == CW'(NSL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Subtraction as a + ~b + ~b_in, one slice per cycle with the carry kept between slices.
  always_comb begin
    w_a_sl  = r_a[r_cnt*SLICE +: SLICE];
    w_b_sl  = r_b[r_cnt*SLICE +: SLICE];
    w_slice = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + {{SLICE{1'b0}}, r_carry};
    w_raw   = r_res;
    w_raw[r_cnt*SLICE +: SLICE] = w_slice[SLICE-1:0];
    w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_raw[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ALU_SUB_SAT_EN
    if (w_ovf) w_final = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else       w_final = w_raw;
`else
    w_final = w_raw;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      d       <= '0;
      sig_N   <= 1'b0;
      sig_Z   <= 1'b0;
      sig_C   <= 1'b0;
      sig_O   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= ~b_in;
        r_cnt   <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_res   <= w_raw;
      r_carry <= w_slice[SLICE];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        d     <= w_final;
        sig_N <= w_final[WIDTH-1];
        sig_Z <= (w_final == '0);
        sig_C <= w_slice[SLICE];
        sig_O <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_sub_seq.sv
// Self-checking bench for alu_sub_seq: directed and random operands against an arithmetic reference model,
// plus backpressure and mid-operation reset. Honours ALU_SUB_SAT_EN like the design.
module tb_alu_sub_seq;

  localparam int NSL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        b_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        sig_N, sig_Z, sig_C, sig_O;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sub_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .sig_N(sig_N), .sig_Z(sig_Z), .sig_C(sig_C), .sig_O(sig_O)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: true signed/unsigned arithmetic on wide integers.
  function automatic logic [35:0] model(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
    longint sdiff;
    longint ua, ub;
    logic [31:0] rd;
    logic n, z, c, o;
    sdiff = longint'($signed(ta)) - longint'($signed(tb_)) - longint'(tbin);
    ua = longint'({32'b0, ta});
    ub = longint'({32'b0, tb_});
    rd = ta - tb_ - {31'b0, tbin};
    c  = (ua >= ub + longint'(tbin));
    o  = (sdiff > 64'sd2147483647) || (sdiff < -64'sd2147483648);
`ifdef ALU_SUB_SAT_EN
    if (o) rd = ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    n = rd[31];
    z = (rd == 32'h0);
    return {rd, n, z, c, o};
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Leaves the bench at the negedge just after the accept edge.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
    wait_ready();
    a = ta; b = tb_; b_in = tbin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; b_in = 1'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  task automatic finish_op(input string tag, input logic [35:0] exp);
    repeat (NSL - 1) @(negedge clk);
    check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_d"}, d, exp[35:4]);
    check({tag, "_flags"}, 32'({sig_N, sig_Z, sig_C, sig_O}), 32'(exp[3:0]));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_, input logic tbin);
    logic [35:0] exp;
    exp = model(ta, tb_, tbin);
    start_op(ta, tb_, tbin);
    finish_op(tag, exp);
    handshake();
  endtask

  initial begin
    logic [35:0] exp;
    logic [31:0] ra, rb;
    logic        rbin;
    logic        stuck;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_d", d, 32'h0);
    check("rst_flags", 32'({sig_N, sig_Z, sig_C, sig_O}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("5m3", 32'd5, 32'd3, 1'b0);
    run_op("3m5", 32'd3, 32'd5, 1'b0);
    run_op("0m0b", 32'd0, 32'd0, 1'b1);
    run_op("eq", 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op("minm1", 32'h8000_0000, 32'd1, 1'b0);
    run_op("maxmneg", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("minm0b", 32'h8000_0000, 32'd0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rbin = 1'($urandom);
      if (i % 4 == 0) rb = {~ra[31], rb[30:0]};
      run_op("rand", ra, rb, rbin);
    end

    // Backpressure: result held while new operands are offered and ignored.
    exp = model(32'h0000_0100, 32'h0000_0200, 1'b1);
    start_op(32'h0000_0100, 32'h0000_0200, 1'b1);
    finish_op("bp", exp);
    stuck = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; b_in = 1'($urandom);
      @(negedge clk);
      if (!out_valid || in_ready || d !== exp[35:4] || {sig_N, sig_Z, sig_C, sig_O} !== exp[3:0])
        stuck = 1'b1;
    end
    check("bp_hold", 32'(stuck), 32'd0);
    in_valid = 1'b0;
    check("bp_d", d, exp[35:4]);
    handshake();

    // Reset during RUN slice 2 discards the operation.
    run_op("pre_rst", 32'd5, 32'd3, 1'b0);
    start_op(32'd3, 32'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_d", d, 32'h0);
    check("mid_rst_flags", 32'({sig_N, sig_Z, sig_C, sig_O}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    for (int i = 0; i < 2 * NSL + 2; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) stuck = 1'b1;
    end
    check("post_rst_quiet", 32'(stuck), 32'd0);
    check("post_rst_d", d, 32'h0);

    run_op("after_rst", 32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
